prog_ram_loader: RTL and testbench

- Program-memory writer for the Apollo core: receives a framed byte stream from a serial receiver and writes 16-bit words into an internal RAM.
- The same RAM serves the core's instruction-fetch read port, replacing the fixed ROM.
- Holds the core (cpu_hold) while a load is in progress, and reports completion or error.

---
 rtl/prog_ram_loader_if.sv | 22 ++
 rtl/prog_ram_loader.sv | 171 +++++++++++++++++
 tb/tb_prog_ram_loader.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/prog_ram_loader_if.sv
// Byte-stream receive and program-RAM read-port bundle
// for prog_ram_loader.
interface prog_ram_loader_if #(
    parameter int AW = 11,
    parameter int DW = 16
);
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          cs;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_out;

    modport master (
        output rx_data, rx_valid, cs, addr,
        input  data_out
    );

    modport slave (
        input  rx_data, rx_valid, cs, addr,
        output data_out
    );
endinterface

// File: rtl/prog_ram_loader.sv
// Framed byte-stream program RAM writer with fetch read port.
// Optional idle timeout: define LOADER_TIMEOUT_EN.
module prog_ram_loader #(
    parameter int AW      = 11,
    parameter int DW      = 16,
    parameter int TO_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    prog_ram_loader_if.slave    bus,
    output logic                busy,
    output logic                cpu_hold,
    output logic                done,
    output logic                err,
    output logic [AW:0]         words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CKSUM
    } state_t;

    localparam logic [16:0] MAX_N = 17'(1) << AW;

    state_t        state_q, state_d;
    logic [AW:0]   wl_q, wl_d;
    logic [AW:0]   len_q, len_d;
    logic [7:0]    hi_q, hi_d;
    logic [7:0]    sum_q, sum_d;
    logic          err_q, err_d;
    logic          done_q, done_d;
    logic [DW-1:0] data_out_q;
    logic          we;
    logic [15:0]   n;

    logic [DW-1:0] mem [2**AW];

`ifdef LOADER_TIMEOUT_EN
    logic [TO_BITS-1:0] to_q, to_d;
`endif

    assign n = {hi_q, bus.rx_data};

    always_comb begin
        state_d = state_q;
        wl_d    = wl_q;
        len_d   = len_q;
        hi_d    = hi_q;
        sum_d   = sum_q;
        err_d   = err_q;
        done_d  = 1'b0;
        we      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LEN_HI;
                    err_d   = 1'b0;
                    wl_d    = '0;
                    sum_d   = '0;
                end
            end
            S_LEN_HI: begin
                if (bus.rx_valid) begin
                    hi_d    = bus.rx_data;
                    sum_d   = sum_q + bus.rx_data;
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (bus.rx_valid) begin
                    sum_d = sum_q + bus.rx_data;
                    if ({1'b0, n} > MAX_N) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else if (n == 16'd0) begin
                        state_d = S_CKSUM;
                    end else begin
                        len_d   = n[AW:0];
                        state_d = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (bus.rx_valid) begin
                    hi_d    = bus.rx_data;
                    sum_d   = sum_q + bus.rx_data;
                    state_d = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (bus.rx_valid) begin
                    we    = 1'b1;
                    wl_d  = wl_q + 1'b1;
                    sum_d = sum_q + bus.rx_data;
                    if (wl_d == len_q) state_d = S_CKSUM;
                    else               state_d = S_DATA_HI;
                end
            end
            S_CKSUM: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == sum_q) done_d = 1'b1;
                    else                      err_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef LOADER_TIMEOUT_EN
        // Counter restarts on every accepted byte; saturation aborts.
        to_d = '0;
        if (state_q != S_IDLE && !bus.rx_valid) begin
            if (to_q == '1) begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end else begin
                to_d = to_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wl_q    <= '0;
            len_q   <= '0;
            hi_q    <= '0;
            sum_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
            to_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            wl_q    <= wl_d;
            len_q   <= len_d;
            hi_q    <= hi_d;
            sum_q   <= sum_d;
            err_q   <= err_d;
            done_q  <= done_d;
`ifdef LOADER_TIMEOUT_EN
            to_q    <= to_d;
`endif
        end
    end

    // RAM contents survive reset; only the read register clears.
    always_ff @(posedge clk) begin
        if (we) mem[wl_q[AW-1:0]] <= {hi_q, bus.rx_data};
    end

    always_ff @(posedge clk) begin
        if (rst)                            data_out_q <= '0;
        else if (bus.cs && state_q == S_IDLE) data_out_q <= mem[bus.addr];
    end

    assign busy         = (state_q != S_IDLE);
    assign cpu_hold     = busy;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = wl_q;
    assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_prog_ram_loader.sv
// Directed self-checking bench for prog_ram_loader.
// Timeout scenario runs only when LOADER_TIMEOUT_EN is defined.
module tb_prog_ram_loader;

    localparam int AW = 11;
    localparam int DW = 16;
`ifdef LOADER_TIMEOUT_EN
    localparam int TO_BITS = 4;
`else
    localparam int TO_BITS = 16;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [AW:0] words_loaded;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int base;

    prog_ram_loader_if #(.AW(AW), .DW(DW)) bus ();

    prog_ram_loader #(
        .AW(AW), .DW(DW), .TO_BITS(TO_BITS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bus          (bus.slave),
        .busy         (busy),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        @(negedge clk);
        bus.cs   = 1'b1;
        bus.addr = a;
        @(negedge clk);
        bus.cs   = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;
        bus.cs       = 1'b0;
        bus.addr     = '0;
        tick(3);
        chk("rst_data_out", 32'(bus.data_out), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_hold", 32'(cpu_hold), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_wl", 32'(words_loaded), 32'h0);
        rst = 1'b0;

        // good two-word load
        base = done_cnt;
        pulse_start();
        chk("t1_busy", 32'(busy), 32'h1);
        chk("t1_hold", 32'(cpu_hold), 32'h1);
        send(8'h00); send(8'h02);
        send(8'h12); send(8'h34);
        send(8'hAB); send(8'hCD);
        chk("t1_wl_pre", 32'(words_loaded), 32'h2);
        chk("t1_busy_pre", 32'(busy), 32'h1);
        send(8'hC0);
        tick(3);
        chk("t1_done_cnt", 32'(done_cnt - base), 32'h1);
        chk("t1_err", 32'(err), 32'h0);
        chk("t1_busy", 32'(busy), 32'h0);
        chk("t1_wl", 32'(words_loaded), 32'h2);
        rd(11'd0);
        chk("t1_rd0", 32'(bus.data_out), 32'h1234);
        rd(11'd1);
        chk("t1_rd1", 32'(bus.data_out), 32'hABCD);
        tick(2);
        chk("t1_rd_hold", 32'(bus.data_out), 32'hABCD);

        // bad checksum
        base = done_cnt;
        pulse_start();
        send(8'h00); send(8'h02);
        send(8'h12); send(8'h34);
        send(8'hAB); send(8'hCD);
        send(8'hC1);
        tick(3);
        chk("t2_done_cnt", 32'(done_cnt - base), 32'h0);
        chk("t2_err", 32'(err), 32'h1);
        chk("t2_busy", 32'(busy), 32'h0);
        rd(11'd0);
        chk("t2_rd0", 32'(bus.data_out), 32'h1234);

        // zero-length frame; start also clears err
        base = done_cnt;
        pulse_start();
        chk("t3_err_clr", 32'(err), 32'h0);
        send(8'h00); send(8'h00); send(8'h00);
        tick(2);
        chk("t3_done_cnt", 32'(done_cnt - base), 32'h1);
        chk("t3_wl", 32'(words_loaded), 32'h0);
        chk("t3_err", 32'(err), 32'h0);

        // length 2049 > 2^11
        base = done_cnt;
        pulse_start();
        send(8'h08); send(8'h01);
        chk("t4_err", 32'(err), 32'h1);
        chk("t4_busy", 32'(busy), 32'h0);
        send(8'h12); send(8'h34);
        tick(2);
        chk("t4_busy_after", 32'(busy), 32'h0);
        chk("t4_wl", 32'(words_loaded), 32'h0);
        chk("t4_done_cnt", 32'(done_cnt - base), 32'h0);

        // length exactly 2^11 is accepted
        pulse_start();
        send(8'h08); send(8'h00);
        chk("t4b_busy", 32'(busy), 32'h1);
        chk("t4b_err", 32'(err), 32'h0);
        do_reset();

        // reset mid-load, reads blocked while busy
        pulse_start();
        send(8'h00); send(8'h01); send(8'hAA);
        rd(11'd1);
        chk("t5_rd_busy", 32'(bus.data_out), 32'h0);
        do_reset();
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_err", 32'(err), 32'h0);
        chk("t5_wl", 32'(words_loaded), 32'h0);
        base = done_cnt;
        pulse_start();
        send(8'h00); send(8'h01);
        send(8'h55); send(8'h66);
        send(8'hBC);
        tick(2);
        chk("t5_done_cnt", 32'(done_cnt - base), 32'h1);
        chk("t5_err2", 32'(err), 32'h0);
        rd(11'd0);
        chk("t5_rd0", 32'(bus.data_out), 32'h5566);
        rd(11'd1);
        chk("t5_rd1", 32'(bus.data_out), 32'hABCD);

        // start with a simultaneous byte: byte dropped
        base = done_cnt;
        @(negedge clk);
        start        = 1'b1;
        bus.rx_data  = 8'h05;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        send(8'h00); send(8'h00); send(8'h00);
        tick(2);
        chk("t6_done_cnt", 32'(done_cnt - base), 32'h1);
        chk("t6_err", 32'(err), 32'h0);

        // stray byte while idle is dropped
        send(8'h77);
        chk("t7_busy", 32'(busy), 32'h0);

`ifdef LOADER_TIMEOUT_EN
        pulse_start();
        send(8'h00);
        tick(13);
        chk("to_busy_early", 32'(busy), 32'h1);
        tick(4);
        chk("to_err", 32'(err), 32'h1);
        chk("to_busy", 32'(busy), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
